// File: rtl/clk_div_ctrl_pkg.sv
// clk_div_ctrl_pkg: shared constants and FSM state type for the divider controller.
//   CNT_W   - default width of the period counter / divisor
//   DEF_DIV - default divisor loaded at reset
//   MIN_DIV - smallest legal period; smaller requests are clamped up to it
//   TCNT_W  - width of burst length and tick counter
package clk_div_ctrl_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned DEF_DIV = 8;
  localparam int unsigned MIN_DIV = 2;
  localparam int unsigned TCNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/clk_div_counter.sv
// clk_div_counter: period counter for clk_div_ctrl. Counts 0..P-1 while enabled,
// P = max(i_div, MIN_DIV), and is cleared (held at 0) while disabled.
//   i_clk    - system clock
//   i_rst    - synchronous active-high reset
//   i_en     - count enable; low clears the counter
//   i_div    - requested period in i_clk cycles
//   o_wrap_c - combinational: enabled and counter at P-1 (last cycle of the period)
module clk_div_counter #(
  parameter int unsigned CNT_W = clk_div_ctrl_pkg::CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_wrap_c
);
  import clk_div_ctrl_pkg::*;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  // Terminal count, with divisors 0 and 1 clamped to the minimum period.
  assign w_last   = (i_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV - 1) : i_div - 1'b1;
  assign o_wrap_c = i_en && (r_cnt == w_last);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
    end else if (o_wrap_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divider controller. Issues a one-cycle tick every P
// clk_in cycles while running, with start/stop, burst-length runs and divisor
// updates that take effect only at period boundaries.
// Optional feature macro: CLK_DIV_CTRL_CLKOUT_EN builds a 50% duty clk_out that
// toggles on every tick; without it clk_out is tied low.
//   clk_in    - system clock          rst       - synchronous active-high reset
//   cfg_div   - requested period      cfg_valid - divisor update request
//   cfg_ready - update can be taken   start     - begin a run (IDLE only)
//   stop      - orderly stop (RUN)    burst_len - ticks per run, 0 = free-run
//   busy      - state != IDLE         tick      - end-of-period enable
//   done      - run ended pulse       tick_cnt  - ticks issued this run
//   clk_out   - divided square wave
module clk_div_ctrl #(
  parameter int unsigned CNT_W   = clk_div_ctrl_pkg::CNT_W,
  parameter int unsigned DEF_DIV = clk_div_ctrl_pkg::DEF_DIV
) (
  input  logic                                clk_in,
  input  logic                                rst,
  input  logic [CNT_W-1:0]                    cfg_div,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic                                start,
  input  logic                                stop,
  input  logic [clk_div_ctrl_pkg::TCNT_W-1:0] burst_len,
  output logic                                busy,
  output logic                                tick,
  output logic                                done,
  output logic [clk_div_ctrl_pkg::TCNT_W-1:0] tick_cnt,
  output logic                                clk_out
);
  import clk_div_ctrl_pkg::*;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_div_act;
  logic [CNT_W-1:0]    r_shadow;
  logic                r_shadow_vld;
  logic                r_done;
  logic [TCNT_W-1:0]   r_tick_cnt;
  logic [TCNT_W-1:0]   r_burst_q;
  logic                w_busy;
  logic                w_tick;
  logic                w_final;
  logic                w_start_acc;
  logic                w_cfg_acc;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_final     = (r_burst_q != '0) && (TCNT_W'(r_tick_cnt + 1'b1) == r_burst_q);
  // The shadow is only ever filled while running and drains at a tick.
  assign cfg_ready   = ~r_shadow_vld;
  assign w_cfg_acc   = cfg_valid & cfg_ready;

  clk_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .i_clk    (clk_in),
    .i_rst    (rst),
    .i_en     (w_busy),
    .i_div    (r_div_act),
    .o_wrap_c (w_tick)
  );

  // Next-state decode; every exit from a running state happens on a tick.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_tick && (w_final || stop)) w_state_nxt = ST_IDLE;
        else if (stop)                   w_state_nxt = ST_STOP_WAIT;
      end
      ST_STOP_WAIT: begin
        if (w_tick) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, done pulse, run bookkeeping.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_done     <= 1'b0;
      r_tick_cnt <= '0;
      r_burst_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_busy && (w_state_nxt == ST_IDLE);
      if (w_start_acc) begin
        r_tick_cnt <= '0;
        r_burst_q  <= burst_len;
      end else if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  // Divisor: direct load when idle, shadowed while running, applied at a tick.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_div_act    <= CNT_W'(DEF_DIV);
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
    end else if (!w_busy) begin
      if (w_cfg_acc) r_div_act <= cfg_div;
    end else if (w_tick) begin
      if (r_shadow_vld) begin
        r_div_act    <= r_shadow;
        r_shadow_vld <= 1'b0;
      end else if (w_cfg_acc) begin
        // Request landing on the boundary itself can go straight in.
        r_div_act <= cfg_div;
      end
    end else if (w_cfg_acc) begin
      r_shadow     <= cfg_div;
      r_shadow_vld <= 1'b1;
    end
  end

`ifdef CLK_DIV_CTRL_CLKOUT_EN
  logic r_clk_out;

  // Toggle per tick; forced low whenever the run ends.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_clk_out <= 1'b0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_clk_out <= 1'b0;
    end else if (w_tick) begin
      r_clk_out <= ~r_clk_out;
    end
  end

  assign clk_out = r_clk_out;
`else
  assign clk_out = 1'b0;
`endif

  assign busy     = w_busy;
  assign tick     = w_tick;
  assign done     = r_done;
  assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed self-checking bench for clk_div_ctrl.
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W = 11;

  logic             clk_in;
  logic             rst;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic [15:0]      burst_len;
  logic             busy;
  logic             tick;
  logic             done;
  logic [15:0]      tick_cnt;
  logic             clk_out;

  int checks = 0;
  int errors = 0;

  clk_div_ctrl #(
    .CNT_W   (CNT_W),
    .DEF_DIV (8)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .busy      (busy),
    .tick      (tick),
    .done      (done),
    .tick_cnt  (tick_cnt),
    .clk_out   (clk_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic exp_c(input logic v);
`ifdef CLK_DIV_CTRL_CLKOUT_EN
    return v;
`else
    return v & 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step n cycles: tick low for n-1 cycles, high on the n-th; clk_out checked if clk >= 0.
  task automatic ticks(input int n, input string tag, input int clk);
    for (int i = 1; i <= n; i++) begin
      step();
      chk($sformatf("%s_tick%0d", tag, i), 32'(tick), (i == n) ? 32'd1 : 32'd0);
      if (clk >= 0)
        chk($sformatf("%s_clk%0d", tag, i), 32'(clk_out), 32'(exp_c(clk[0])));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_div = '0; burst_len = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tcnt", 32'(tick_cnt), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_clk", 32'(clk_out), 32'd0);

    // Free-run at default P=8, then stop at cnt=3.
    start = 1'b1; step(); start = 1'b0;
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_tick0", 32'(tick), 32'd0);
    ticks(7, "s1_t1", 0);
    chk("s1_tcnt0", 32'(tick_cnt), 32'd0);
    ticks(8, "s1_t2", 1);
    chk("s1_tcnt1", 32'(tick_cnt), 32'd1);
    ticks(8, "s1_t3", 0);
    chk("s1_tcnt2", 32'(tick_cnt), 32'd2);
    chk("s1_nodone", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s1_clkhi", 32'(clk_out), 32'(exp_c(1'b1)));
    end
    chk("s1_tcnt3", 32'(tick_cnt), 32'd3);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd1);
    ticks(3, "stop_t", 1);
    chk("stop_nodone", 32'(done), 32'd0);
    step();
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_busy0", 32'(busy), 32'd0);
    chk("stop_tick0", 32'(tick), 32'd0);
    chk("stop_tcnt", 32'(tick_cnt), 32'd4);
    chk("stop_clk0", 32'(clk_out), 32'd0);
    step();
    chk("stop_done1", 32'(done), 32'd0);

    // Burst of 3 at P=5; burst_len latched at start.
    cfg_div = 11'd5; cfg_valid = 1'b1;
    chk("s2_ready", 32'(cfg_ready), 32'd1);
    step(); cfg_valid = 1'b0;
    burst_len = 16'd3; start = 1'b1; step(); start = 1'b0; burst_len = 16'd9;
    ticks(4, "s2_t1", -1);
    ticks(5, "s2_t2", -1);
    chk("s2_tcnt1", 32'(tick_cnt), 32'd1);
    ticks(5, "s2_t3", -1);
    chk("s2_busy", 32'(busy), 32'd1);
    step();
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_busy0", 32'(busy), 32'd0);
    chk("s2_tcnt3", 32'(tick_cnt), 32'd3);
    chk("s2_tick0", 32'(tick), 32'd0);

    // Back-to-back start in the done cycle; stop on the final burst tick.
    start = 1'b1; burst_len = 16'd3; step(); start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    chk("b2b_tcnt", 32'(tick_cnt), 32'd0);
    ticks(4, "b2b_t1", -1);
    ticks(5, "b2b_t2", -1);
    ticks(5, "b2b_t3", -1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_busy0", 32'(busy), 32'd0);
    step();
    chk("b2b_single", 32'(done), 32'd0);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Divisor update mid-period: 8 -> 4 at cnt=2.
    cfg_div = 11'd8; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    burst_len = 16'd0; start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("s3_ready1", 32'(cfg_ready), 32'd1);
    cfg_div = 11'd4; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    chk("s3_ready0", 32'(cfg_ready), 32'd0);
    ticks(4, "s3_old", -1);
    chk("s3_pend", 32'(cfg_ready), 32'd0);
    step();
    chk("s3_ready_back", 32'(cfg_ready), 32'd1);
    chk("s3_tick0", 32'(tick), 32'd0);
    ticks(3, "s3_new1", -1);
    ticks(4, "s3_new2", -1);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    ticks(2, "s3_stop", -1);
    step();
    chk("s3_done", 32'(done), 32'd1);

    // Divisors 0 and 1 behave as period 2.
    cfg_div = 11'd0; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    burst_len = 16'd2; start = 1'b1; step(); start = 1'b0;
    ticks(1, "d0_t1", -1);
    ticks(2, "d0_t2", -1);
    step();
    chk("d0_done", 32'(done), 32'd1);
    cfg_div = 11'd1; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    burst_len = 16'd1; start = 1'b1; step(); start = 1'b0;
    ticks(1, "d1_t1", -1);
    step();
    chk("d1_done", 32'(done), 32'd1);

    // Reset mid-run with a pending shadow.
    cfg_div = 11'd5; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    burst_len = 16'd0; start = 1'b1; step(); start = 1'b0;
    ticks(4, "mr_t1", -1);
    step();
    cfg_div = 11'd3; cfg_valid = 1'b1; step(); cfg_valid = 1'b0;
    chk("mr_pend", 32'(cfg_ready), 32'd0);
    chk("mr_tcnt1", 32'(tick_cnt), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_tick", 32'(tick), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_tcnt", 32'(tick_cnt), 32'd0);
    chk("mr_ready", 32'(cfg_ready), 32'd1);
    chk("mr_clk", 32'(clk_out), 32'd0);
    step();
    chk("mr_nodone", 32'(done), 32'd0);
    burst_len = 16'd1; start = 1'b1; step(); start = 1'b0;
    ticks(7, "mr_def", 0);
    step();
    chk("mr_done2", 32'(done), 32'd1);
    chk("mr_clk2", 32'(clk_out), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
